fmac: RTL

FMAC -- requirements
Module: fmac

---
 rtl/fmac.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fmac.sv
// Pipelined signed multiply / multiply-accumulate with saturating accumulator
// and saturating narrowed result; clock_enable freezes the whole pipeline.
module fmac #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 32,
  parameter int PIPE      = 4,
  parameter int FRAC      = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        clock_enable,
  input  logic                        in_valid,
  input  logic signed [WIDTH-1:0]     a,
  input  logic signed [WIDTH-1:0]     b,
  input  logic                        acc_en,
  input  logic                        acc_clear,
  output logic                        out_valid,
  output logic signed [WIDTH-1:0]     res,
  output logic signed [ACC_WIDTH-1:0] acc,
  output logic                        res_sat,
  output logic                        acc_ovf
);

  if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("fmac: WIDTH must be in 4..32");
  end
  if (ACC_WIDTH < 2*WIDTH) begin : g_bad_acc
    $error("fmac: ACC_WIDTH must be >= 2*WIDTH");
  end
  if (PIPE < 2 || PIPE > 8) begin : g_bad_pipe
    $error("fmac: PIPE must be in 2..8");
  end
  if (FRAC < 0 || FRAC > 2*WIDTH-1) begin : g_bad_frac
    $error("fmac: FRAC must be in 0..2*WIDTH-1");
  end

  localparam int PW = 2*WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] RES_MAX = {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] RES_MIN = {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef struct packed {
    logic vld;
    logic acc_en;
    logic clr;
  } ctl_t;

  // Control travels alongside the data; stage 0 is the operand register.
  ctl_t                    vld_pipe_q [PIPE-1];
  logic signed [WIDTH-1:0] a_q, b_q;
  logic signed [PW-1:0]    mul, fin_prod;
  ctl_t                    fin;

  assign mul = PW'(a_q) * PW'(b_q);
  assign fin = vld_pipe_q[PIPE-2];

  always_ff @(posedge clock) begin
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
      for (int i = 0; i < PIPE-1; i++) vld_pipe_q[i] <= '0;
    end else if (clock_enable) begin
      a_q <= a;
      b_q <= b;
      vld_pipe_q[0] <= '{vld: in_valid, acc_en: acc_en, clr: acc_clear};
      for (int i = 1; i < PIPE-1; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
    end
  end

  if (PIPE == 2) begin : g_prod_comb
    assign fin_prod = mul;
  end else begin : g_prod_reg
    logic signed [PW-1:0] prod_q [1:PIPE-2];
    always_ff @(posedge clock) begin
      if (!reset) begin
        for (int i = 1; i <= PIPE-2; i++) prod_q[i] <= '0;
      end else if (clock_enable) begin
        prod_q[1] <= mul;
        for (int i = 2; i <= PIPE-2; i++) prod_q[i] <= prod_q[i-1];
      end
    end
    assign fin_prod = prod_q[PIPE-2];
  end

  logic                        out_valid_q, out_valid_d;
  logic signed [WIDTH-1:0]     res_q, res_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        res_sat_q, res_sat_d;
  logic                        acc_ovf_q, acc_ovf_d;

  logic signed [ACC_WIDTH-1:0] prod_ext, sum_sat, acc_new, narrow_src, shifted;
  logic signed [ACC_WIDTH:0]   sum;
  logic                        sum_ovf, clamp_hi, clamp_lo;

  // Final stage: the accumulator feeds back from its own register, so
  // back-to-back accumulates see the previous result without a stall.
  always_comb begin
    prod_ext    = ACC_WIDTH'(fin_prod);
    sum         = (ACC_WIDTH+1)'(acc_q) + (ACC_WIDTH+1)'(prod_ext);
    sum_ovf     = sum[ACC_WIDTH] != sum[ACC_WIDTH-1];
    sum_sat     = sum_ovf ? (sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : sum[ACC_WIDTH-1:0];
    acc_new     = fin.clr ? prod_ext : sum_sat;
    narrow_src  = fin.acc_en ? acc_new : prod_ext;
    shifted     = narrow_src >>> FRAC;
    clamp_hi    = shifted > RES_MAX;
    clamp_lo    = shifted < RES_MIN;

    out_valid_d = fin.vld;
    res_d       = res_q;
    acc_d       = acc_q;
    res_sat_d   = res_sat_q;
    acc_ovf_d   = acc_ovf_q;
    if (fin.vld) begin
      res_sat_d = clamp_hi | clamp_lo;
      res_d     = clamp_hi ? RES_MAX[WIDTH-1:0] :
                  clamp_lo ? RES_MIN[WIDTH-1:0] : shifted[WIDTH-1:0];
      if (fin.acc_en) begin
        acc_d     = acc_new;
        acc_ovf_d = fin.clr ? 1'b0 : (acc_ovf_q | sum_ovf);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      acc_q       <= '0;
      res_sat_q   <= 1'b0;
      acc_ovf_q   <= 1'b0;
    end else if (clock_enable) begin
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      acc_q       <= acc_d;
      res_sat_q   <= res_sat_d;
      acc_ovf_q   <= acc_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign acc       = acc_q;
  assign res_sat   = res_sat_q;
  assign acc_ovf   = acc_ovf_q;

endmodule
